// File: rtl/mul5xn_seq_ctrl.sv
// mul5xn_seq_ctrl: 5 x WB unsigned sequential multiplier.
// One 5x2 combinational core is reused over N = WB/2 cycles. Each cycle it
// consumes one 2-bit slice of B and adds the shifted partial product into
// an accumulator. Operands arrive over a valid/ready handshake, and the
// product leaves over a second valid/ready handshake.
// WB must be even and at least 2.

// nr_5x2: combinational 5-bit x 2-bit unsigned multiplier core.
module nr_5x2 (
    input  logic [4:0] a,
    input  logic [1:0] b,
    output logic [6:0] p
);

    logic [6:0] pp0;
    logic [6:0] pp1;

    // Two gated partial products. The second one carries weight 2.
    always_comb begin
        pp0 = 7'd0;
        pp1 = 7'd0;
        if (b[0]) begin
            pp0 = {2'b00, a};
        end
        if (b[1]) begin
            pp1 = {1'b0, a, 1'b0};
        end
        p = pp0 + pp1;
    end

endmodule

module mul5xn_seq_ctrl #(
    parameter int WB = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      a,
    input  logic [WB-1:0]   b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WB+4:0]   p,
    output logic            busy
);

    localparam int N  = WB / 2;
    localparam int PW = 5 + WB;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [4:0]      a_reg;
    logic [WB-1:0]   b_reg;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   p_reg;
    logic [KW-1:0]   k;

    logic [KW:0]     shift_amt;
    logic [WB-1:0]   b_shifted;
    logic [1:0]      core_b;
    logic [6:0]      core_p;
    logic [PW-1:0]   pp_shifted;
    logic [PW-1:0]   acc_sum;
    logic            last_slice;
    logic            accept;

    // Slice k of B sits at bit 2k. Its partial product is weighted by 2^(2k).
    assign shift_amt  = {k, 1'b0};
    assign b_shifted  = b_reg >> shift_amt;
    assign core_b     = b_shifted[1:0];
    assign last_slice = (k == K_LAST);

    nr_5x2 u_core (
        .a (a_reg),
        .b (core_b),
        .p (core_p)
    );

    assign pp_shifted = PW'(core_p) << shift_amt;
    assign acc_sum    = acc + pp_shifted;

    // Flush beats a new operand in IDLE, so acceptance is gated by it.
    assign accept = (state == IDLE) && in_valid && !flush;

    // Status outputs decode straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign p         = p_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Flush has priority in every state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!flush && in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, slice accumulation and result latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            k     <= '0;
            p_reg <= '0;
        end else begin
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
                acc   <= '0;
                k     <= '0;
            end else if ((state == RUN) && !flush) begin
                acc <= acc_sum;
                if (last_slice) begin
                    p_reg <= acc_sum;
                    k     <= '0;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

endmodule
